// File: rtl/random_pulse_monitor.sv
// random_pulse_monitor
//   Receive-side statistics block for an asynchronous pulse stream.
//   The input is synchronized, rising edges are detected and counted, and the
//   edge-to-edge gap (in clk cycles) is tracked as last/min/max. A stall flag
//   rises when no edge has been seen for TIMEOUT cycles while measuring.
//   All results are read back one byte at a time through sel/data_out.
//
//   Optional build macro RANDOM_PULSE_MONITOR_WIDTH_EN adds a high-time
//   measurement (last_width, readable on sel 8/9). Without it sel 8/9 read 0.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset (all flops, synchronizer included)
//   en        measurement enable
//   clr       synchronous clear of all statistics (highest priority)
//   pulse_in  asynchronous pulse stream
//   sel       readout byte select
//   data_out  selected statistic byte, registered (1-cycle latency)
//   edge_stb  one-cycle strobe per accepted rising edge
//   valid     at least one gap recorded since reset/clr
//   stall     no edge for TIMEOUT cycles while measuring
//
// Readout map (sel): 0/1 pulse_cnt, 2/3 last_gap, 4/5 min_gap, 6/7 max_gap,
//   8/9 last_width, 10 status {5'b0, stall, valid, measuring}, others 0x00.
module random_pulse_monitor #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic       pulse_in,
   input  logic [3:0] sel,
   output logic [7:0] data_out,
   output logic       edge_stb,
   output logic       valid,
   output logic       stall
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   // Readout bytes are taken from a 16-bit view; narrower counters are
   // zero-extended so their upper bytes read as zero.
   localparam int EXT_W = (CNT_W > 16) ? CNT_W : 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   function automatic logic [15:0] ext16(input logic [CNT_W-1:0] v);
      logic [EXT_W-1:0] w;
      w = EXT_W'(v);
      return w[15:0];
   endfunction

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   hist_p1;
   logic                   sync_out;
   logic                   rise;
   logic                   active;
   logic                   take;

   logic [CNT_W-1:0]       pulse_cnt;
   logic [CNT_W-1:0]       last_gap;
   logic [CNT_W-1:0]       min_gap;
   logic [CNT_W-1:0]       max_gap;
   logic [CNT_W-1:0]       gap_cnt, gap_d;
   logic                   stall_d;

   logic [15:0]            pulse_cnt16, last_gap16, min_gap16, max_gap16;
   logic [15:0]            width16;
   logic [7:0]             rd_byte;

   // ---- stage 0/1: input synchronizer and edge history ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         hist_p1 <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pulse_in};
         hist_p1 <= sync_p0[SYNC_STAGES-1];
      end
   end

   assign sync_out = sync_p0[SYNC_STAGES-1];
   assign rise     = sync_out & ~hist_p1;

   // An edge is accepted only while measuring is enabled in ARMED/MEASURE;
   // an edge coinciding with clr is dropped entirely.
   assign active = en && (state_q != IDLE);
   assign take   = rise && active && !clr;

   // ---- stage 2: FSM, gap counter and stall ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gap_cnt <= '0;
         stall   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_cnt <= gap_d;
         stall   <= stall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_cnt;
      stall_d = 1'b0;
      if (clr) begin
         state_d = en ? ARMED : IDLE;
         gap_d   = '0;
      end else if (!en) begin
         // gap_cnt is held; re-entry to MEASURE always restarts it at 1,
         // so a gap spanning a disabled period is never recorded.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARMED;
            end
            ARMED: begin
               if (rise) begin
                  state_d = MEASURE;
                  gap_d   = CNT_ONE;
               end
            end
            MEASURE: begin
               gap_d = rise ? CNT_ONE : sat_inc(gap_cnt);
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      // Computed from next-state values so stall drops the cycle after an
      // edge, a clr or leaving MEASURE.
      stall_d = (state_d == MEASURE) && (gap_d >= TIMEOUT_C);
   end

   // ---- stage 2: edge strobe and statistics ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_stb  <= 1'b0;
         valid     <= 1'b0;
         pulse_cnt <= '0;
         last_gap  <= '0;
         min_gap   <= '1;
         max_gap   <= '0;
      end else begin
         edge_stb <= take;
         if (clr) begin
            valid     <= 1'b0;
            pulse_cnt <= '0;
            last_gap  <= '0;
            min_gap   <= '1;
            max_gap   <= '0;
         end else if (take) begin
            pulse_cnt <= sat_inc(pulse_cnt);
            // The first edge after arming only starts the gap timer.
            if (state_q == MEASURE) begin
               last_gap <= gap_cnt;
               valid    <= 1'b1;
               if (gap_cnt < min_gap) begin
                  min_gap <= gap_cnt;
               end
               if (gap_cnt > max_gap) begin
                  max_gap <= gap_cnt;
               end
            end
         end
      end
   end

`ifdef RANDOM_PULSE_MONITOR_WIDTH_EN
   logic             fall;
   logic [CNT_W-1:0] width_cnt;
   logic [CNT_W-1:0] last_width;

   assign fall = ~sync_out & hist_p1;

   // ---- stage 2: high-time measurement ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_cnt  <= '0;
         last_width <= '0;
      end else if (clr) begin
         width_cnt  <= '0;
         last_width <= '0;
      end else if (!active) begin
         width_cnt  <= '0;
      end else if (fall) begin
         last_width <= width_cnt;
         width_cnt  <= '0;
      end else if (sync_out) begin
         width_cnt  <= sat_inc(width_cnt);
      end
   end

   assign width16 = ext16(last_width);
`else
   assign width16 = 16'h0000;
`endif

   assign pulse_cnt16 = ext16(pulse_cnt);
   assign last_gap16  = ext16(last_gap);
   assign min_gap16   = ext16(min_gap);
   assign max_gap16   = ext16(max_gap);

   always_comb begin
      rd_byte = 8'h00;
      case (sel)
         4'd0:    rd_byte = pulse_cnt16[7:0];
         4'd1:    rd_byte = pulse_cnt16[15:8];
         4'd2:    rd_byte = last_gap16[7:0];
         4'd3:    rd_byte = last_gap16[15:8];
         4'd4:    rd_byte = min_gap16[7:0];
         4'd5:    rd_byte = min_gap16[15:8];
         4'd6:    rd_byte = max_gap16[7:0];
         4'd7:    rd_byte = max_gap16[15:8];
         4'd8:    rd_byte = width16[7:0];
         4'd9:    rd_byte = width16[15:8];
         4'd10:   rd_byte = {5'b00000, stall, valid, (state_q == MEASURE)};
         default: rd_byte = 8'h00;
      endcase
   end

   // ---- stage 3: registered readout (shows pre-update statistics) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= 8'h00;
      end else begin
         data_out <= rd_byte;
      end
   end

endmodule
